// File: rtl/rf_commit_sequencer.sv
// Commit-to-register-file sequencer: in-order FIFO feeding the single RF write port,
// with a drain-then-acknowledge flush on pipeline clear.
module rf_commit_sequencer #(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clearIn,
    input  logic                 commitValid,
    output logic                 commitReady,
    input  logic [4:0]           commitDest,
    input  logic [31:0]          commitValue,
    input  logic [ROB_WIDTH-1:0] commitRobId,
    output logic                 regUpdateValid,
    output logic [4:0]           regUpdateDest,
    output logic [31:0]          regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    output logic [DEPTH_LOG:0]   pendingCount,
    output logic                 flushDoneOut
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG;
    localparam int unsigned CW    = DEPTH_LOG + 1;

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t                 state, state_next;
    logic                   flush_next;
    logic [DEPTH_LOG-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]          count, count_next;
    logic                   enq, deq;

    logic [4:0]             dest_q  [DEPTH];
    logic [31:0]            value_q [DEPTH];
    logic [ROB_WIDTH-1:0]   robid_q [DEPTH];

    // x0 commits complete the handshake but never occupy a slot
    assign commitReady = resetIn && (state == RUN) && (count < CW'(DEPTH));
    assign enq         = commitValid && commitReady && (commitDest != 5'd0);
    assign deq         = (count != '0);
    assign count_next  = count + CW'(enq) - CW'(deq);

    assign regUpdateValid = deq;
    assign regUpdateDest  = dest_q[rd_ptr];
    assign regUpdateValue = value_q[rd_ptr];
    assign regUpdateRobId = robid_q[rd_ptr];
    assign pendingCount   = count;

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state        <= RUN;
            flushDoneOut <= 1'b0;
        end else begin
            state        <= state_next;
            flushDoneOut <= flush_next;
        end
    end

    // Flush acknowledges once everything already retired has been written
    always_comb begin
        state_next = state;
        flush_next = 1'b0;
        case (state)
            RUN: begin
                if (clearIn) begin
                    if (count_next != '0) state_next = DRAIN;
                    else                  flush_next = !flushDoneOut;
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next = RUN;
                    flush_next = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (enq) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
            if (deq) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
        end
    end

    // Payload storage needs no reset; validity comes from count
    always_ff @(posedge clockIn) begin
        if (enq) begin
            dest_q[wr_ptr]  <= commitDest;
            value_q[wr_ptr] <= commitValue;
            robid_q[wr_ptr] <= commitRobId;
        end
    end

endmodule

// File: doc/rf_commit_sequencer.md
# rf_commit_sequencer

Sequences committed results from the reorder buffer onto the register file's single write port: one register write per cycle, in commit order. A small in-order FIFO decouples ROB commit bursts from the write port. On a pipeline clear, the block keeps draining already-committed entries so architectural state stays intact, then signals flush completion. The block sits between the ROB commit stage and the register file's `regUpdate*` inputs.

## Interface
- `ROB_WIDTH`, 4, width of ROB entry id
- `DEPTH_LOG`, 2, log2 of FIFO depth (default depth 4)

- `clockIn`  in  1  clock; all state updates on rising edge
- `resetIn`  in  1  reset, asynchronous, active-low
- `clearIn`  in  1  synchronous pipeline clear request, level sampled per cycle
- `commitValid`  in  1  ROB presents a committed result
- `commitReady`  out  1  block accepts a commit this cycle
- `commitDest`  in  5  destination architectural register
- `commitValue`  in  32  result value
- `commitRobId`  in  ROB_WIDTH  ROB id of committing entry
- `regUpdateValid`  out  1  register file write strobe
- `regUpdateDest`  out  5  write destination
- `regUpdateValue`  out  32  write value
- `regUpdateRobId`  out  ROB_WIDTH  ROB id of the write, used by the register file to release its constraint
- `pendingCount`  out  DEPTH_LOG+1  number of queued entries
- `flushDoneOut`  out  1  one-cycle pulse: clear complete, all prior commits written

## Operation
- Handshake: accept when `commitValid && commitReady` at a rising edge.
- `commitReady = resetIn && state==RUN && pendingCount < 2**DEPTH_LOG`.
- Accepted commits with `commitDest == 0` are consumed but not enqueued (x0 is never written).
- FIFO head drives `regUpdate*` combinationally. `regUpdateValid = (pendingCount != 0)`.
- The register file always takes the write, so the head is dequeued every cycle `regUpdateValid` is high. Strict FIFO order applies.
- Same-cycle enqueue and dequeue are allowed: count is unchanged and pointers both advance.
- Pointers are DEPTH_LOG bits and wrap modulo depth. The count is tracked separately.
- States:
  - RUN
    - `clearIn` = 1 and the post-update count is not 0 → DRAIN.
    - `clearIn` = 1 and the post-update count is 0 → RUN, with `flushDoneOut` = 1 in the next cycle.
  - DRAIN
    - `commitReady` = 0; dequeue continues.
    - When the post-update count reaches 0 → RUN, with `flushDoneOut` = 1 in the next cycle.
    - `clearIn` is ignored in DRAIN.
- A commit handshake in the same cycle as `clearIn` (RUN only) is accepted and drained, because it is already architecturally retired.
- `flushDoneOut` is registered and is never high for more than one consecutive cycle.

## Timing
- Reset (`resetIn` = 0, asynchronous): count 0, pointers 0, state RUN, `flushDoneOut` 0, `regUpdateValid` 0, `commitReady` 0. `commitReady` rises once `resetIn` = 1.
- Latency: a commit accepted at edge N appears on `regUpdate*` in the cycle after edge N, and is written at edge N+1.
- Throughput: one commit accepted and one write per cycle, sustained.
- Full: `commitReady` is low when count equals depth. There is no bypass, so an accept on a full FIFO is impossible even with a same-cycle dequeue.
- Empty: `regUpdate*` data outputs are don't-care, with `regUpdateValid` 0.
- Clear timing: with k entries queued after the clear edge, `flushDoneOut` pulses exactly k cycles after that edge. With k = 0 it pulses 1 cycle after.
- Reset asserted mid-DRAIN: all entries are discarded immediately and no `flushDoneOut` is produced.

## Test plan
- Reset, then a single commit (dest 5, value 0x1234, id 3) → next cycle `regUpdateValid` = 1, dest 5, value 0x1234, id 3; cycle after that `regUpdateValid` = 0.
- Back-to-back commits dest 1..6, one per cycle → writes dest 1..6 on consecutive cycles in order, `commitReady` never drops, `pendingCount` ≤ 1.
- Four commits, then a fifth with the write port unable to keep up (fill by accepting 4 while checking count) → `commitReady` = 0 at count 4. No fifth accept occurs until a dequeue frees a slot.
- `commitDest` = 0 with value 0xDEAD → handshake completes, `pendingCount` unchanged, no `regUpdateValid`.
- Three entries queued, `clearIn` pulsed with a concurrent commit (dest 7) → state DRAIN, `commitReady` 0, four writes in order ending with dest 7, `flushDoneOut` high exactly one cycle, then `commitReady` returns to 1.
- `resetIn` low mid-DRAIN with two entries → `regUpdateValid` drops immediately (asynchronously), count 0, no `flushDoneOut` pulse after release.
